// File: rtl/pwm_capture_pkg.sv
// pwm_capture shared types and constants.
// State encoding and counter saturation helper.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  function automatic logic [31:0] cnt_max(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture result bus.
// Master drives measurements, slave consumes.
interface pwm_capture_if #(
  parameter int CNT_WIDTH = 16
);

  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] high_time;
  logic                 valid;
  logic                 timeout;
  logic                 stuck_level;

  modport master (
    output period,
    output high_time,
    output valid,
    output timeout,
    output stuck_level
  );

  modport slave (
    input period,
    input high_time,
    input valid,
    input timeout,
    input stuck_level
  );

endinterface

// File: rtl/pwm_capture_in_filter.sv
// pwm_in_filter: inversion, synchroniser and glitch filter.
// rise/fall flag the edge at which level is about to flip.
module pwm_in_filter #(
  parameter int   SYNC_STAGES  = 2,
  parameter int   FILTER_LEN   = 3,
  parameter logic ACTIVE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic settled
);

  localparam int CW   = $clog2(FILTER_LEN + 1);
  localparam int FILL = SYNC_STAGES + FILTER_LEN - 1;
  localparam logic [CW-1:0] RUN_LAST =
    CW'(FILTER_LEN - 1);

  logic                   in_act;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   level_q;
  logic                   level_d;
  logic [CW-1:0]          run_q;
  logic [CW-1:0]          run_d;
  logic                   flip;
  logic [FILL-1:0]        fill_q;

  assign in_act = (pwm_in == ACTIVE_LEVEL);
  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_act};
    end
  end

  always_comb begin
    flip    = (sample != level_q) &&
              (run_q == RUN_LAST);
    level_d = level_q;
    run_d   = '0;
    if (flip) begin
      level_d = sample;
    end else if (sample != level_q) begin
      run_d = run_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      run_q   <= '0;
    end else begin
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

  // settled marks the point where a level present at
  // reset release has had time to reach the filter output
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= {fill_q[FILL-2:0], 1'b1};
    end
  end

  assign level   = level_q;
  assign rise    = flip & sample;
  assign fall    = flip & ~sample;
  assign settled = fill_q[FILL-1];

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: PWM period / high-time measurement.
// FSM, saturating cycle counter and result registers.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int   CNT_WIDTH    = 16,
  parameter int   SYNC_STAGES  = 2,
  parameter int   FILTER_LEN   = 3,
  parameter logic ACTIVE_LEVEL = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pwm_in,
  pwm_capture_if.master  cap
);

  localparam logic [CNT_WIDTH-1:0] T_MAX =
    CNT_WIDTH'(cnt_max(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] T_ONE =
    CNT_WIDTH'(1);

  logic level;
  logic rise;
  logic fall;
  logic settled;
  logic sat;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] t_q, t_d;
  logic [CNT_WIDTH-1:0] hi_q, hi_d;
  logic [CNT_WIDTH-1:0] per_q, per_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic                 valid_q, valid_d;
  logic                 to_q, to_d;
  logic                 stuck_q, stuck_d;

  pwm_in_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_LEN   (FILTER_LEN),
    .ACTIVE_LEVEL (ACTIVE_LEVEL)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .settled (settled)
  );

  // a rise landing on saturation completes the period
  assign sat = (t_q == T_MAX) && !to_q && !rise;

  always_comb begin
    state_d = state_q;
    t_d     = (t_q == T_MAX) ? t_q : t_q + T_ONE;
    hi_d    = hi_q;
    per_d   = per_q;
    high_d  = high_q;
    valid_d = 1'b0;
    to_d    = to_q;
    stuck_d = stuck_q;
    if (rise) begin
      t_d = T_ONE;
    end
    unique case (state_q)
      WAIT_LOW: begin
        if (settled && !level && !rise) begin
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          hi_d    = t_q;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          per_d   = t_q;
          high_d  = hi_q;
          valid_d = 1'b1;
          to_d    = 1'b0;
          state_d = HIGH;
        end
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase
    if (sat) begin
      to_d    = 1'b1;
      stuck_d = level;
      per_d   = '0;
      high_d  = '0;
      if (state_q == HIGH || state_q == LOW) begin
        state_d = level ? WAIT_LOW : WAIT_RISE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOW;
      t_q     <= '0;
      hi_q    <= '0;
      per_q   <= '0;
      high_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      high_q  <= high_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      stuck_q <= stuck_d;
    end
  end

  assign cap.period      = per_q;
  assign cap.high_time   = high_q;
  assign cap.valid       = valid_q;
  assign cap.timeout     = to_q;
  assign cap.stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks on three configurations.
// a: defaults, b: CNT_WIDTH=8, c: ACTIVE_LEVEL=0.
module tb_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic pa, pb, pc;

  int checks = 0;
  int errors = 0;
  int va = 0;
  int vb = 0;
  int snap;

  pwm_capture_if #(.CNT_WIDTH(16)) a_if ();
  pwm_capture_if #(.CNT_WIDTH(8))  b_if ();
  pwm_capture_if #(.CNT_WIDTH(16)) c_if ();

  pwm_capture #(
    .CNT_WIDTH(16), .SYNC_STAGES(2),
    .FILTER_LEN(3), .ACTIVE_LEVEL(1'b1)
  ) u_a (
    .clk(clk), .rst(rst_a), .pwm_in(pa), .cap(a_if)
  );

  pwm_capture #(
    .CNT_WIDTH(8), .SYNC_STAGES(2),
    .FILTER_LEN(3), .ACTIVE_LEVEL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst_b), .pwm_in(pb), .cap(b_if)
  );

  pwm_capture #(
    .CNT_WIDTH(16), .SYNC_STAGES(2),
    .FILTER_LEN(3), .ACTIVE_LEVEL(1'b0)
  ) u_c (
    .clk(clk), .rst(rst_c), .pwm_in(pc), .cap(c_if)
  );

  always_ff @(posedge clk) begin
    va <= va + int'(a_if.valid);
    vb <= vb + int'(b_if.valid);
  end

  function automatic logic [15:0] f_per(input int w);
    case (w)
      0:       return a_if.period;
      1:       return {8'h00, b_if.period};
      default: return c_if.period;
    endcase
  endfunction

  function automatic logic [15:0] f_high(input int w);
    case (w)
      0:       return a_if.high_time;
      1:       return {8'h00, b_if.high_time};
      default: return c_if.high_time;
    endcase
  endfunction

  function automatic logic f_val(input int w);
    case (w)
      0:       return a_if.valid;
      1:       return b_if.valid;
      default: return c_if.valid;
    endcase
  endfunction

  function automatic logic f_to(input int w);
    case (w)
      0:       return a_if.timeout;
      1:       return b_if.timeout;
      default: return c_if.timeout;
    endcase
  endfunction

  function automatic logic f_stk(input int w);
    case (w)
      0:       return a_if.stuck_level;
      1:       return b_if.stuck_level;
      default: return c_if.stuck_level;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d want %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int w, input logic act);
    case (w)
      0:       pa = act;
      1:       pb = act;
      default: pc = ~act;
    endcase
  endtask

  // active phase of h cycles; valid expected 5 cycles in
  task automatic pulse(input int w, input int h,
                       input logic ev,
                       input int ep, input int eh);
    drive(w, 1'b1);
    step(4);
    chk("valid_early", 32'(f_val(w)), 0);
    step(1);
    chk("valid_at_rise", 32'(f_val(w)), 32'(ev));
    if (ev) begin
      chk("period", 32'(f_per(w)), ep);
      chk("high_time", 32'(f_high(w)), eh);
      chk("timeout_on_valid", 32'(f_to(w)), 0);
    end
    step(1);
    chk("valid_one_cycle", 32'(f_val(w)), 0);
    step(h - 6);
    drive(w, 1'b0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    pa = 1'b0; pb = 1'b0; pc = 1'b1;
    step(3);
    for (int w = 0; w < 3; w++) begin
      chk("rst_period", 32'(f_per(w)), 0);
      chk("rst_high", 32'(f_high(w)), 0);
      chk("rst_valid", 32'(f_val(w)), 0);
      chk("rst_timeout", 32'(f_to(w)), 0);
      chk("rst_stuck", 32'(f_stk(w)), 0);
    end

    // steady 1000/250 waveform
    rst_a = 1'b0;
    step(10);
    pulse(0, 250, 1'b0, 0, 0);
    step(750);
    pulse(0, 250, 1'b1, 1000, 250);
    step(750);
    pulse(0, 250, 1'b1, 1000, 250);
    chk("a_timeout", 32'(a_if.timeout), 0);

    // 2-cycle glitch in the low phase
    step(300);
    snap = va;
    drive(0, 1'b1);
    step(2);
    drive(0, 1'b0);
    step(448);
    chk("glitch_no_valid", va, snap);
    pulse(0, 250, 1'b1, 1000, 250);

    // 3-cycle pulse is accepted
    step(300);
    drive(0, 1'b1);
    step(3);
    drive(0, 1'b0);
    step(1);
    chk("p3_valid_early", 32'(a_if.valid), 0);
    step(1);
    chk("p3_valid", 32'(a_if.valid), 1);
    chk("p3_period", 32'(a_if.period), 550);
    chk("p3_high", 32'(a_if.high_time), 250);
    step(445);
    pulse(0, 250, 1'b1, 450, 3);
    step(750);
    pulse(0, 250, 1'b1, 1000, 250);
    step(750);

    // reset in the middle of a high phase
    drive(0, 1'b1);
    step(100);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    chk("mid_rst_period", 32'(a_if.period), 0);
    chk("mid_rst_high", 32'(a_if.high_time), 0);
    chk("mid_rst_valid", 32'(a_if.valid), 0);
    chk("mid_rst_timeout", 32'(a_if.timeout), 0);
    snap = va;
    step(149);
    drive(0, 1'b0);
    step(750);
    pulse(0, 250, 1'b0, 0, 0);
    step(750);
    chk("mid_rst_no_valid", va, snap);
    pulse(0, 250, 1'b1, 1000, 250);

    // CNT_WIDTH=8 timeout with stuck-high input
    rst_b = 1'b0;
    step(10);
    pulse(1, 30, 1'b0, 0, 0);
    step(70);
    pulse(1, 30, 1'b1, 100, 30);
    step(70);
    pulse(1, 30, 1'b1, 100, 30);
    step(70);
    drive(1, 1'b1);
    step(259);
    chk("b_to_early", 32'(b_if.timeout), 0);
    step(1);
    chk("b_timeout", 32'(b_if.timeout), 1);
    chk("b_stuck", 32'(b_if.stuck_level), 1);
    chk("b_to_period", 32'(b_if.period), 0);
    chk("b_to_high", 32'(b_if.high_time), 0);
    step(40);
    chk("b_to_hold", 32'(b_if.timeout), 1);
    drive(1, 1'b0);
    step(70);
    snap = vb;
    pulse(1, 30, 1'b0, 0, 0);
    step(70);
    chk("b_resume_no_valid", vb, snap);
    chk("b_to_before", 32'(b_if.timeout), 1);
    pulse(1, 30, 1'b1, 100, 30);

    // inverted input, 400 period, 100 low
    rst_c = 1'b0;
    step(10);
    pulse(2, 100, 1'b0, 0, 0);
    step(300);
    pulse(2, 100, 1'b1, 400, 100);
    step(300);
    pulse(2, 100, 1'b1, 400, 100);
    chk("c_timeout", 32'(c_if.timeout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform and reports its period and high time in clk cycles.
- Sits on the input side of the motor-control datapath. Typical sources: a magnetic encoder's PWM output, or loop-back of a gate signal for dead-time and duty self-check.
- Complements the PWM generator: that block turns counts into edges, this one turns edges back into counts.
- Flags stuck (0 %/100 % duty or absent) inputs via timeout.

Parameters:
- CNT_WIDTH, 16: width of the period/high_time counters and outputs.
- SYNC_STAGES, 2: metastability flops on pwm_in (minimum 2).
- FILTER_LEN, 3: consecutive equal samples required before the filtered level changes (minimum 1).
- ACTIVE_LEVEL, 1'b1: input level treated as "high". If 0, pwm_in is inverted at entry.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- pwm_in  in  1  asynchronous PWM input.
- period  out  CNT_WIDTH  cycles between the last two filtered rising edges.
- high_time  out  CNT_WIDTH  filtered active cycles within that period.
- valid  out  1  one-cycle strobe when period/high_time update.
- timeout  out  1  no edge seen for 2^CNT_WIDTH-1 cycles.
- stuck_level  out  1  filtered level at the moment timeout asserted.

Behaviour:
- Reset (synchronous, rst=1 sampled on clk):
  - sync chain and filtered level = 0 (inactive, after inversion).
  - period = 0, high_time = 0, valid = 0, timeout = 0, stuck_level = 0.
  - counter t = 0; state = WAIT_LOW.
  - Reset mid-measurement discards the partial measurement; no valid is produced.
- Input path:
  - Optional inversion, then SYNC_STAGES flops, then filter.
  - The filter changes its level only after FILTER_LEN consecutive synced samples differ from the current level.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - Edge latency pwm_in to filtered = SYNC_STAGES+FILTER_LEN cycles, identical for both edges, so measurements are unbiased.
- Edges: rise/fall are one-cycle pulses from the filtered level vs. its previous value.
- Counter t:
  - Saturating at 2^CNT_WIDTH-1.
  - Set to 1 on every rise; otherwise increments every cycle in all states.
- States:
  - WAIT_LOW: filtered level 0 -> WAIT_RISE. Prevents a level that is already high at reset release from being taken as a rising edge.
  - WAIT_RISE: on rise -> HIGH, t = 1. No valid.
  - HIGH: on fall -> hi_tmp = t, go to LOW.
  - LOW: on rise -> period = t, high_time = hi_tmp, valid = 1 for one cycle, t = 1, go to HIGH.
  - Values are exact: rises N cycles apart with a fall H cycles after the first rise yield period = N, high_time = H.
- Timeout:
  - When t reaches saturation in any state (and timeout = 0): timeout = 1, stuck_level = filtered level, period = 0, high_time = 0.
  - If in HIGH/LOW -> WAIT_LOW if the level is 1, or WAIT_RISE if the level is 0.
  - Timeout stays high until the next valid, and clears in the same cycle valid pulses.
- Simultaneous events: rise and saturation in the same cycle -> the rise wins (measurement completes, no timeout).
- Outputs are registered. period/high_time hold their values between valid strobes.
- valid is never asserted on the first rise after WAIT_RISE.

Decomposition:
- Shared package pwm_capture_pkg: state encoding constants (WAIT_LOW = 0, WAIT_RISE = 1, HIGH = 2, LOW = 3) and the counter saturation constant function of CNT_WIDTH.
- One sub-module, pwm_in_filter: inversion, SYNC_STAGES synchroniser and FILTER_LEN glitch filter. It outputs the filtered level plus rise/fall pulses.
- The top module holds the FSM, counter and output registers.

Test Plan:
- Steady waveform, period 1000 cycles, active 250 cycles, default parameters -> no valid on the 1st rise. Each later rise gives valid, 5 cycles after the pwm_in edge, with period = 1000, high_time = 250. timeout stays 0.
- 2-cycle high glitch inside the low phase of the above waveform (FILTER_LEN = 3) -> no extra valid, values unchanged. A 3-cycle pulse is accepted and corrupts that cycle's reading as expected.
- CNT_WIDTH = 8, pwm_in held high after two good periods -> timeout = 1 and stuck_level = 1 exactly 255 cycles after the last filtered rise; period = high_time = 0. Resuming the waveform gives the first valid after low plus two rises, and timeout clears on that valid.
- pwm_in already high when rst deasserts -> no valid until the line goes low and then rises twice. First reported period equals the true period.
- rst pulsed for 1 cycle in the middle of a HIGH phase -> all outputs 0 the next cycle; no valid from the interrupted period.
- ACTIVE_LEVEL = 0, inverted waveform with period 400 cycles and 100 cycles low -> period = 400, high_time = 100.
